// File: rtl/frame_grab_pkg.sv
// Shared types and constants for the frame grab controller: FSM states,
// host register map and STATUS bit positions.
package frame_grab_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE,
    ERROR
  } state_t;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_X0    = 3'd1;
  localparam logic [2:0] ADDR_Y0    = 3'd2;
  localparam logic [2:0] ADDR_W     = 3'd3;
  localparam logic [2:0] ADDR_H     = 3'd4;
  localparam logic [2:0] ADDR_PIXEL = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_TRUNC  = 3;
  localparam int STAT_EMPTY  = 4;
  localparam int STAT_CNT_LO = 8;

endpackage

// File: rtl/pixel_fifo.sv
// 24-bit show-ahead synchronous FIFO; pop data is combinational from the head entry.
// Push on full is dropped unless a pop happens in the same cycle; flush empties it in one cycle.
module pixel_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            push,
  input  logic [23:0]                     push_data,
  input  logic                            pop,
  output logic [23:0]                     pop_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(FIFO_DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_grab_ctrl.sv
// Host-armed capture of a rectangular window of the VGA pixel stream into a FIFO drained over Avalon-MM.
// readdata latency 1; no stream backpressure: a push into a full, unpopped FIFO drops the pixel and errors out.
module frame_grab_ctrl
  import frame_grab_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [15:0] writedata,
  input  logic        read,
  output logic [23:0] readdata,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        VGA_BLANK_n,
  input  logic        VSYNC,
  input  logic        pix_en,
  output logic        capture_active,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t               state, state_nxt;
  logic [COORD_W-1:0]   x0, y0, w, h, x_cnt, y_cnt;
  logic [COORD_W:0]     x_ext, y_ext, x_end, y_end;
  logic                 blank_q, vsync_q, vs_fall, blank_fall;
  logic                 done_f, ovf_f, trunc_f;
  logic                 ctrl_wr, start, abort, clear, reg_wr, zero_win;
  logic                 pix_try, in_win, last_pix, pop, overflow_hit;
  logic                 push, flag_clr, set_done, set_ovf, set_trunc;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [23:0]          fifo_dat, status;
  logic                 busy;
  logic                 unused_wdata;

  assign unused_wdata = &{1'b0, writedata[15:COORD_W]};

  assign ctrl_wr  = chipselect && write && (address == ADDR_CTRL);
  assign start    = ctrl_wr && writedata[CTRL_START];
  assign abort    = ctrl_wr && writedata[CTRL_ABORT];
  assign clear    = ctrl_wr && writedata[CTRL_CLEAR];
  assign reg_wr   = chipselect && write && ((state == IDLE) || (state == DONE));
  assign zero_win = (w == '0) || (h == '0);
  assign pop      = chipselect && read && (address == ADDR_PIXEL) && !fifo_empty;

  assign vs_fall    = vsync_q && !VSYNC;
  assign blank_fall = blank_q && !VGA_BLANK_n;

  // Window bounds are one bit wider than the coordinates so X0+W cannot wrap.
  assign x_ext    = {1'b0, x_cnt};
  assign y_ext    = {1'b0, y_cnt};
  assign x_end    = {1'b0, x0} + {1'b0, w};
  assign y_end    = {1'b0, y0} + {1'b0, h};
  assign in_win   = (x_ext >= {1'b0, x0}) && (x_ext < x_end) &&
                    (y_ext >= {1'b0, y0}) && (y_ext < y_end);
  assign last_pix = (x_ext == x_end - (COORD_W+1)'(1)) && (y_ext == y_end - (COORD_W+1)'(1));
  assign pix_try  = pix_en && VGA_BLANK_n && in_win;
  assign overflow_hit = fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start) state_nxt = zero_win ? DONE : ARMED;
        ARMED:             if (vs_fall) state_nxt = CAPTURE;
        CAPTURE: begin
          if (pix_try && overflow_hit)  state_nxt = ERROR;
          else if (pix_try && last_pix) state_nxt = DONE;
          else if (vs_fall)             state_nxt = ERROR;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    flag_clr  = clear;
    set_done  = 1'b0;
    set_ovf   = 1'b0;
    set_trunc = 1'b0;
    if (abort) begin
      flag_clr = 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start) begin
          flag_clr = 1'b1;
          set_done = zero_win;
        end
        CAPTURE: begin
          if (pix_try) begin
            push     = !overflow_hit;
            set_ovf  = overflow_hit;
            set_done = !overflow_hit && last_pix;
          end
          set_trunc = vs_fall && !set_ovf && !set_done;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state == ARMED) || (state == CAPTURE);
  assign capture_active = (state == CAPTURE);
  assign irq            = done_f || ovf_f || trunc_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_f  <= 1'b0;
      ovf_f   <= 1'b0;
      trunc_f <= 1'b0;
    end else begin
      if (flag_clr) begin
        done_f  <= 1'b0;
        ovf_f   <= 1'b0;
        trunc_f <= 1'b0;
      end
      if (set_done)  done_f  <= 1'b1;
      if (set_ovf)   ovf_f   <= 1'b1;
      if (set_trunc) trunc_f <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0 <= '0;
      y0 <= '0;
      w  <= '0;
      h  <= '0;
    end else if (reg_wr) begin
      case (address)
        ADDR_X0: x0 <= writedata[COORD_W-1:0];
        ADDR_Y0: y0 <= writedata[COORD_W-1:0];
        ADDR_W:  w  <= writedata[COORD_W-1:0];
        ADDR_H:  h  <= writedata[COORD_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b0;
      vsync_q <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      blank_q <= VGA_BLANK_n;
      vsync_q <= VSYNC;
      if (!VGA_BLANK_n) x_cnt <= '0;
      else if (pix_en)  x_cnt <= x_cnt + COORD_W'(1);
      if (!VSYNC)          y_cnt <= '0;
      else if (blank_fall) y_cnt <= y_cnt + COORD_W'(1);
    end
  end

  always_comb begin
    status                      = '0;
    status[STAT_BUSY]           = busy;
    status[STAT_DONE]           = done_f;
    status[STAT_OVF]            = ovf_f;
    status[STAT_TRUNC]          = trunc_f;
    status[STAT_EMPTY]          = fifo_empty;
    status[STAT_CNT_LO +: 8]    = 8'(fifo_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      case (address)
        ADDR_CTRL:  readdata <= status;
        ADDR_X0:    readdata <= 24'(x0);
        ADDR_Y0:    readdata <= 24'(y0);
        ADDR_W:     readdata <= 24'(w);
        ADDR_H:     readdata <= 24'(h);
        ADDR_PIXEL: readdata <= fifo_empty ? '0 : fifo_dat;
        default:    readdata <= '0;
      endcase
    end
  end

  pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (push),
    .push_data ({VGA_R, VGA_G, VGA_B}),
    .pop       (pop),
    .pop_data  (fifo_dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
